// File: rtl/digit_latch_buf_if.sv
// Digit bus between the counter/scaler and the display latch.
// The master drives new results and controls; the slave returns the displayed state.
interface digit_latch_buf_if #(
  parameter int DIGITS = 4,
  parameter int DW     = 5
);
  logic [DIGITS*DW-1:0] data_in;
  logic                 load;
  logic                 hold;
  logic                 clear;
  logic [DIGITS*DW-1:0] data_out;
  logic                 valid;
  logic                 pending;
  logic                 stale;
  logic [7:0]           update_cnt;

  modport master (
    output data_in, load, hold, clear,
    input  data_out, valid, pending, stale, update_cnt
  );

  modport slave (
    input  data_in, load, hold, clear,
    output data_out, valid, pending, stale, update_cnt
  );
endinterface

// File: rtl/digit_latch_buf.sv
// Double-buffered digit latch: hold parks the newest result in a shadow,
// which is shown on release. It also tracks staleness and counts display updates.
module digit_latch_buf #(
  parameter int DIGITS       = 4,
  parameter int DW           = 5,
  parameter int STALE_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  digit_latch_buf_if.slave     bus
);
  localparam int W  = DIGITS * DW;
  localparam int CW = $clog2(STALE_CYCLES + 1);
  localparam logic [CW-1:0] STALE_MAX = CW'(STALE_CYCLES);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LIVE  = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

  state_t          r_state, w_state_next;
  logic [W-1:0]    r_display, w_display_next;
  logic [W-1:0]    r_shadow, w_shadow_next;
  logic            r_valid, w_valid_next;
  logic [CW-1:0]   r_stale_cnt, w_stale_cnt_next;
  logic [7:0]      r_update_cnt, w_update_cnt_next;
  logic            w_update;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_display    <= '0;
      r_shadow     <= '0;
      r_valid      <= 1'b0;
      r_stale_cnt  <= '0;
      r_update_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_display    <= w_display_next;
      r_shadow     <= w_shadow_next;
      r_valid      <= w_valid_next;
      r_stale_cnt  <= w_stale_cnt_next;
      r_update_cnt <= w_update_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_display_next = r_display;
    w_shadow_next  = r_shadow;
    w_valid_next   = r_valid;
    w_update       = 1'b0;

    if (bus.clear) begin
      w_state_next   = ST_EMPTY;
      w_display_next = '0;
      w_shadow_next  = '0;
      w_valid_next   = 1'b0;
    end else begin
      unique case (r_state)
        ST_EMPTY, ST_LIVE: begin
          if (bus.load && bus.hold) begin
            w_shadow_next = bus.data_in;
            w_state_next  = ST_PEND;
          end else if (bus.load) begin
            w_display_next = bus.data_in;
            w_update       = 1'b1;
            w_state_next   = ST_LIVE;
          end
        end
        ST_PEND: begin
          if (bus.hold) begin
            if (bus.load) begin
              w_shadow_next = bus.data_in;
            end
          end else begin
            // A load coinciding with release wins over the parked shadow.
            w_display_next = bus.load ? bus.data_in : r_shadow;
            w_shadow_next  = '0;
            w_update       = 1'b1;
            w_state_next   = ST_LIVE;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
      if (w_update) begin
        w_valid_next = 1'b1;
      end
    end
  end

  always_comb begin
    w_update_cnt_next = r_update_cnt;
    w_stale_cnt_next  = r_stale_cnt;
    if (bus.clear) begin
      w_update_cnt_next = '0;
      w_stale_cnt_next  = '0;
    end else if (w_update) begin
      w_update_cnt_next = r_update_cnt + 8'd1;
      w_stale_cnt_next  = '0;
    end else if (!r_valid) begin
      w_stale_cnt_next = '0;
    end else if (r_stale_cnt != STALE_MAX) begin
      w_stale_cnt_next = r_stale_cnt + 1'b1;
    end
  end

  assign bus.data_out   = r_display;
  assign bus.valid      = r_valid;
  assign bus.pending    = (r_state == ST_PEND);
  assign bus.stale      = r_valid && (r_stale_cnt == STALE_MAX);
  assign bus.update_cnt = r_update_cnt;
endmodule

// File: tb/tb_digit_latch_buf.sv
// Bench for digit_latch_buf: directed scenarios followed by random traffic,
// each cycle compared against a behavioural model of the latch.
module tb_digit_latch_buf;
  localparam int DIGITS = 4;
  localparam int DW     = 5;
  localparam int STALE  = 8;
  localparam int W      = DIGITS * DW;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  digit_latch_buf_if #(.DIGITS(DIGITS), .DW(DW)) bus ();

  digit_latch_buf #(.DIGITS(DIGITS), .DW(DW), .STALE_CYCLES(STALE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: what is shown, what is parked, and cycles since last update.
  logic [W-1:0] m_disp, m_shadow;
  bit           m_valid, m_pend;
  int           m_ucnt, m_since;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit upd = 0;
    if (reset || bus.clear) begin
      m_disp = '0; m_shadow = '0; m_valid = 0; m_pend = 0; m_ucnt = 0; m_since = 0;
    end else begin
      if (m_pend && !bus.hold) begin
        m_disp = bus.load ? bus.data_in : m_shadow;
        m_pend = 0;
        upd    = 1;
      end else if (bus.load && bus.hold) begin
        m_shadow = bus.data_in;
        m_pend   = 1;
      end else if (bus.load) begin
        m_disp = bus.data_in;
        upd    = 1;
      end
      if (upd) begin
        m_valid = 1;
        m_ucnt  = (m_ucnt + 1) % 256;
        m_since = 0;
      end else if (m_valid) begin
        m_since = (m_since < STALE) ? m_since + 1 : STALE;
      end else begin
        m_since = 0;
      end
    end
  endtask

  // One clock: apply inputs, advance model, compare every output after the edge.
  task automatic cyc(input bit r, input bit l, input bit h, input bit c,
                     input logic [W-1:0] d, input string tag);
    reset = r; bus.load = l; bus.hold = h; bus.clear = c; bus.data_in = d;
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".data_out"}, 32'(bus.data_out), 32'(m_disp));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(m_valid));
    chk({tag, ".pending"}, 32'(bus.pending), 32'(m_pend));
    chk({tag, ".stale"}, 32'(bus.stale), 32'(m_valid && (m_since == STALE)));
    chk({tag, ".update_cnt"}, 32'(bus.update_cnt), 32'(m_ucnt));
  endtask

  initial begin
    logic [W-1:0] rd;
    logic [7:0]   u0;
    reset = 1'b1; bus.load = 0; bus.hold = 0; bus.clear = 0; bus.data_in = '0;
    m_disp = '0; m_shadow = '0; m_valid = 0; m_pend = 0; m_ucnt = 0; m_since = 0;

    // 1: reset then idle
    cyc(1, 0, 0, 0, '0, "t1_rst");
    cyc(1, 0, 0, 0, '0, "t1_rst");
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, '0, "t1_idle");
    chk("t1_dout_zero", 32'(bus.data_out), 32'h0);

    // 2: load, go stale, reload
    cyc(0, 1, 0, 0, 20'h12345, "t2_load");
    chk("t2_dout", 32'(bus.data_out), 32'h12345);
    chk("t2_ucnt", 32'(bus.update_cnt), 32'd1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, '0, "t2_idle");
    chk("t2_stale_on", 32'(bus.stale), 32'd1);
    cyc(0, 1, 0, 0, 20'h0ABCD, "t2_reload");
    chk("t2_stale_off", 32'(bus.stale), 32'd0);
    chk("t2_ucnt2", 32'(bus.update_cnt), 32'd2);

    // 3: hold with two loads, release shows newest
    cyc(0, 1, 0, 0, 20'h11111, "t3_base");
    u0 = bus.update_cnt;
    cyc(0, 1, 1, 0, 20'h22222, "t3_h1");
    cyc(0, 1, 1, 0, 20'h33333, "t3_h2");
    chk("t3_frozen", 32'(bus.data_out), 32'h11111);
    chk("t3_pend", 32'(bus.pending), 32'd1);
    cyc(0, 0, 0, 0, '0, "t3_rel");
    chk("t3_shown", 32'(bus.data_out), 32'h33333);
    chk("t3_ucnt", 32'(bus.update_cnt), 32'(u0 + 8'd1));

    // 4: release coinciding with load
    cyc(0, 1, 1, 0, 20'h44444, "t4_park");
    u0 = bus.update_cnt;
    cyc(0, 1, 0, 0, 20'h55555, "t4_rel_load");
    chk("t4_dout", 32'(bus.data_out), 32'h55555);
    chk("t4_pend", 32'(bus.pending), 32'd0);
    chk("t4_ucnt", 32'(bus.update_cnt), 32'(u0 + 8'd1));

    // 5: clear beats load, then update counter wraps
    cyc(0, 1, 0, 1, 20'hFFFFF, "t5_clear");
    chk("t5_dout", 32'(bus.data_out), 32'h0);
    chk("t5_valid", 32'(bus.valid), 32'd0);
    for (int i = 0; i < 256; i++) cyc(0, 1, 0, 0, W'($urandom), "t5_wrap");
    chk("t5_wrap_cnt", 32'(bus.update_cnt), 32'd0);
    chk("t5_wrap_stale", 32'(bus.stale), 32'd0);

    // 6: reset mid-pend loses shadow
    cyc(0, 1, 1, 0, 20'h0F0F0, "t6_park");
    cyc(1, 0, 1, 0, '0, "t6_rst");
    cyc(0, 0, 0, 0, '0, "t6_rel");
    chk("t6_dout", 32'(bus.data_out), 32'h0);
    chk("t6_valid", 32'(bus.valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rd = W'($urandom);
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 149) == 0), rd, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/digit_latch_buf.md
# digit_latch_buf

Parametrised, double-buffered output latch for the digit bus of the auto-scaled LF counter. It captures DIGITS digit codes of DW bits on a load strobe and holds them for the display driver. A hold (freeze) input defers updates into a one-deep shadow buffer, so the newest pending result is shown on release. The block also flags stale readings and counts display updates. It sits between the gate-time counter/scaler and the display multiplexer.

## Interface
- DIGITS, default 4: number of digit channels.
- DW, default 5: bits per digit code.
- STALE_CYCLES, default 50_000_000: clk cycles without a display update before `stale` asserts; must be ≥1.
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DIGITS*DW  packed digit codes; digit k occupies bits [k*DW +: DW], with digit 0 least significant.
- load  in  1  single-cycle strobe: data_in is a new result.
- hold  in  1  level input: freeze displayed value while high.
- clear  in  1  synchronous blank of all contents.
- data_out  out  DIGITS*DW  displayed digit codes, same packing as data_in.
- valid  out  1  data_out holds a loaded result.
- pending  out  1  shadow holds a result not yet displayed.
- stale  out  1  no display update for STALE_CYCLES cycles while valid.
- update_cnt  out  8  number of display updates, modulo 256.

## Operation
- Storage:
  - display register (drives data_out);
  - shadow register (DIGITS*DW);
  - 2-bit state;
  - stale counter, width $clog2(STALE_CYCLES+1);
  - update_cnt.
- Priority order: reset > clear > load/hold logic.
- reset or clear: display, shadow and stale counter go to 0; update_cnt goes to 0; state goes to EMPTY; valid, pending and stale go to 0.
- States and transitions:
  - EMPTY: valid=0, pending=0.
    - load & !hold: display <= data_in, go to LIVE.
    - load & hold: shadow <= data_in, go to PEND.
  - LIVE: valid=1, pending=0.
    - load & !hold: display <= data_in, stay in LIVE.
    - load & hold: shadow <= data_in, go to PEND; display unchanged.
  - PEND: pending=1; valid is unchanged from the state PEND was entered from (0 if entered from EMPTY).
    - hold & load: shadow <= data_in (newest wins), stay in PEND.
    - !hold & load: display <= data_in and the shadow is discarded, go to LIVE.
    - !hold & !load: display <= shadow, go to LIVE.
- Display update: any cycle in which the display register is written by load or by a shadow transfer. Reset and clear writes are not display updates.
- Each display update increments update_cnt by exactly 1, wrapping 255 -> 0.
- Stale counter:
  - cleared to 0 on every display update;
  - otherwise increments each cycle while valid=1, saturating at STALE_CYCLES;
  - held at 0 while valid=0.
- stale = valid & (stale counter == STALE_CYCLES).
- hold with no load in LIVE or EMPTY changes nothing (the state does not change).
- No arithmetic is performed on digit contents; codes pass through bit-exact.

## Timing
- All outputs are registered.
- Latency from load (or from hold falling with pending=1) to data_out, valid and update_cnt changing: 1 cycle.
- pending rises 1 cycle after load & hold, and falls 1 cycle after the cycle in which hold is low.
- stale asserts STALE_CYCLES cycles after the last display update, and deasserts the cycle after the next update, clear or reset.
- A load in the same cycle as hold falls in PEND: data_in is displayed, and update_cnt increments once, not twice.
- A load in the same cycle as clear is ignored; the block ends EMPTY.
- Reset in mid-PEND: the shadow is lost, and the next load behaves as from EMPTY.
- Continuous load every cycle with hold=0: the display updates every cycle, update_cnt increments every cycle, and stale stays 0.

## Test plan
Parameters: DIGITS=4, DW=5, STALE_CYCLES=8.
1. Reset for 2 cycles, then idle for 20 -> data_out=0, valid=0, pending=0, stale=0, update_cnt=0 throughout.
2. load data_in=20'h12345 with hold=0 -> next cycle data_out=20'h12345, valid=1, update_cnt=1; after 8 idle cycles stale=1; load 20'h0ABCD -> stale=0 the cycle after, update_cnt=2.
3. Starting with 20'h11111 displayed:
   - hold=1, load 20'h22222 then 20'h33333 -> data_out stays 20'h11111, pending=1;
   - drop hold -> next cycle data_out=20'h33333, pending=0, update_cnt incremented by 1.
4. From PEND (shadow holding 20'h44444), drop hold in the same cycle as load 20'h55555 -> data_out=20'h55555 (the shadow is not shown), pending=0, single increment.
5. Clear asserted together with load 20'hFFFFF -> next cycle data_out=0, valid=0, update_cnt=0. After 256 further hold=0 loads, update_cnt=0 (wrap).
6. Reset while pending=1 -> all outputs 0. Then hold=0 with no load -> data_out stays 0, valid stays 0.
